// File: rtl/rv32i_types.sv
// rv32i_types: shared pipeline-control state encoding and NOP constants.
package rv32i_types;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        IF_WAIT  = 2'd2
    } pc_state_t;

    typedef struct packed {
        logic       reg_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       branch;
        logic       jump;
        logic [3:0] alu_op;
    } ctrl_word_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam ctrl_word_t  NOP_CTRL  = '0;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use hazard between the IF_ID sources and the ID_EX load.
module hazard_detect (
    input  logic       ex_load,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    output logic       hazard
);
    always_comb begin
        hazard = ex_load && ex_rd != 5'd0 &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/bubble control for a 5-stage pipeline with
// stall and flush statistics and a memory-wait watchdog.
module pipeline_ctrl
    import rv32i_types::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_load,
    input  logic [4:0]  ex_rd,
    input  logic        br_taken,
    output logic        load_front,
    output logic        load_back,
    output logic        flush_if_id,
    output logic        bubble,
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic        wd_err
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    pc_state_t     state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [31:0]   stall_q, stall_d;
    logic [15:0]   flush_q, flush_d;
    logic          wd_q, wd_d;
    logic          hazard, dstall, go;

    hazard_detect u_hazard (
        .ex_load    (ex_load),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .hazard     (hazard)
    );

    // Outputs are purely combinational so a cleared stall advances with no added latency.
    always_comb begin
        dstall      = dmem_req && !dmem_resp;
        go          = reset_n && !dstall && imem_resp;
        load_back   = go;
        load_front  = go && (br_taken || !hazard);
        flush_if_id = go && br_taken;
        bubble      = go && (br_taken || hazard);
        state_d     = dstall ? MEM_WAIT : !imem_resp ? IF_WAIT : RUN;
        wait_d      = state_q != MEM_WAIT ? '0 :
                      wait_q == WW'(MAX_WAIT) ? wait_q : wait_q + WW'(1);
        wd_d        = wd_q || (state_q == MEM_WAIT && wait_d == WW'(MAX_WAIT));
        stall_d     = (load_back || &stall_q) ? stall_q : stall_q + 32'd1;
        flush_d     = flush_q + {15'd0, flush_if_id};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
            wd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
            wd_q    <= wd_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
    assign wd_err    = wd_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and randomized checks against a priority-rule reference model.
module tb_pipeline_ctrl;
    import rv32i_types::*;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset_n, imem_resp, dmem_req, dmem_resp;
    logic        id_use_rs1, id_use_rs2, ex_load, br_taken;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        load_front, load_back, flush_if_id, bubble, wd_err;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;

    int     errors = 0;
    int     checks = 0;
    longint m_stall;
    int     m_flush, m_wait, m_st;
    bit     m_wd;

    pipeline_ctrl #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset_n(reset_n), .imem_resp(imem_resp), .dmem_req(dmem_req),
        .dmem_resp(dmem_resp), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .ex_load(ex_load), .ex_rd(ex_rd), .br_taken(br_taken),
        .load_front(load_front), .load_back(load_back), .flush_if_id(flush_if_id),
        .bubble(bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wd_err(wd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        m_stall = 0; m_flush = 0; m_wait = 0; m_st = 0; m_wd = 0;
    endtask

    task automatic expect_out(output bit lf, output bit lb, output bit fl, output bit bu);
        bit hz;
        hz = ex_load && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        {lf, lb, fl, bu} = 4'b0000;
        if (!reset_n || (dmem_req && !dmem_resp) || !imem_resp) {lf, lb, fl, bu} = 4'b0000;
        else if (br_taken) {lf, lb, fl, bu} = 4'b1111;
        else if (hz)       {lf, lb, fl, bu} = 4'b0101;
        else               {lf, lb, fl, bu} = 4'b1100;
    endtask

    task automatic check_all(input string tag);
        bit lf, lb, fl, bu;
        pc_state_t st;
        expect_out(lf, lb, fl, bu);
        st = m_st == 1 ? MEM_WAIT : m_st == 2 ? IF_WAIT : RUN;
        chk({tag, ".load_front"}, {31'd0, load_front}, {31'd0, lf});
        chk({tag, ".load_back"}, {31'd0, load_back}, {31'd0, lb});
        chk({tag, ".flush_if_id"}, {31'd0, flush_if_id}, {31'd0, fl});
        chk({tag, ".bubble"}, {31'd0, bubble}, {31'd0, bu});
        chk({tag, ".stall_cnt"}, stall_cnt, m_stall[31:0]);
        chk({tag, ".flush_cnt"}, {16'd0, flush_cnt}, m_flush);
        chk({tag, ".wd_err"}, {31'd0, wd_err}, {31'd0, m_wd});
        chk({tag, ".state"}, 32'(dut.state_q), 32'(st));
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic step(input string tag);
        bit lf, lb, fl, bu;
        #2;
        if (!reset_n) model_reset();
        check_all(tag);
        expect_out(lf, lb, fl, bu);
        @(posedge clk);
        if (!reset_n) model_reset();
        else begin
            if (!lb && m_stall != 64'hFFFF_FFFF) m_stall++;
            if (fl) m_flush = (m_flush + 1) % 65536;
            m_wait = m_st == 1 ? (m_wait < MAXW ? m_wait + 1 : m_wait) : 0;
            if (m_st == 1 && m_wait >= MAXW) m_wd = 1;
            m_st = (dmem_req && !dmem_resp) ? 1 : !imem_resp ? 2 : 0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        imem_resp = 1; dmem_req = 0; dmem_resp = 0; br_taken = 0;
        ex_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    endtask

    initial begin
        reset_n = 0;
        idle();
        model_reset();
        @(negedge clk);
        imem_resp = 0; dmem_req = 1; br_taken = 1;
        step("rst_a");
        step("rst_b");
        idle();
        reset_n = 1;
        repeat (4) step("run");

        ex_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        step("hz");
        ex_load = 0;
        step("hz_after");

        ex_load = 1; br_taken = 1;
        step("br_hz");
        idle();
        step("br_after");

        dmem_req = 1;
        repeat (3) step("dstall");
        dmem_resp = 1;
        step("dresp");
        idle();
        step("dstall_after");
        chk("dstall_total", stall_cnt, 32'd3);

        br_taken = 1; dmem_req = 1;
        repeat (2) step("br_stall");
        dmem_resp = 1;
        step("br_release");
        idle();
        step("br_release_after");

        imem_resp = 0;
        repeat (2) step("fstall");
        idle();
        step("fstall_after");

        dmem_req = 1;
        repeat (6) step("wd_wait");
        dmem_resp = 1;
        step("wd_resp");
        idle();
        step("wd_after");
        chk("wd_sticky", {31'd0, wd_err}, 32'd1);

        dmem_req = 1;
        repeat (2) step("mid_wait");
        br_taken = 1;
        #2;
        reset_n = 0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        idle();
        step("post_rst");

        repeat (6) begin
            reset_n = 0;
            step("rnd_rst");
            reset_n = 1;
            repeat (300) begin
                dmem_req   = $urandom_range(0, 2) == 0;
                dmem_resp  = $urandom_range(0, 1) == 1;
                imem_resp  = $urandom_range(0, 4) != 0;
                br_taken   = $urandom_range(0, 4) == 0;
                ex_load    = $urandom_range(0, 1) == 1;
                ex_rd      = 5'($urandom_range(0, 3));
                id_rs1     = 5'($urandom_range(0, 3));
                id_rs2     = 5'($urandom_range(0, 3));
                id_use_rs1 = $urandom_range(0, 1) == 1;
                id_use_rs2 = $urandom_range(0, 1) == 1;
                step("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 255: memory-wait cycle limit before the watchdog error is raised.
REQ-002 clk  input  1  pipeline clock; all state updates on posedge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 imem_resp  input  1  instruction fetch completes this cycle.
REQ-005 dmem_req  input  1  EX_MEM-stage control word requests a data read or write.
REQ-006 dmem_resp  input  1  data access completes this cycle.
REQ-007 id_rs1, id_rs2  input  5 each  source registers of the instruction in IF_ID.
REQ-008 id_use_rs1, id_use_rs2  input  1 each  matching source register is actually read.
REQ-009 ex_load  input  1  ID_EX-stage control word is a load.
REQ-010 ex_rd  input  5  destination register in ID_EX.
REQ-011 br_taken  input  1  EX stage resolves a taken branch or jump.
REQ-012 load_front  output  1  load enable for PC and the IF_ID slot.
REQ-013 load_back  output  1  shift enable for the ID_EX, EX_MEM and MEM_WB slots of the PC/IR and control-word shift registers.
REQ-014 flush_if_id  output  1  replace the IF_ID entry with a NOP (32'h0) on the next load.
REQ-015 bubble  output  1  insert an all-zero control word into ID_EX instead of the decoded word.
REQ-016 stall_cnt  output  32  saturating count of cycles with load_back=0.
REQ-017 flush_cnt  output  16  wrapping count of branch flushes.
REQ-018 wd_err  output  1  sticky memory-watchdog error.

Function
REQ-019 FSM states SHALL be RUN, MEM_WAIT and IF_WAIT; the state register is the only control storage.
REQ-020 Hazard = ex_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-021 Per-cycle priority SHALL be: data stall > fetch stall > branch flush > load-use hazard > normal advance.
REQ-022 Data stall (dmem_req & !dmem_resp) SHALL drive load_front=0, load_back=0, bubble=0, flush_if_id=0 and set next state MEM_WAIT.
REQ-023 Fetch stall (no data stall, !imem_resp) SHALL drive all four outputs 0 and set next state IF_WAIT.
REQ-024 Branch flush (no stall, br_taken) SHALL drive load_front=1, load_back=1, flush_if_id=1, bubble=1; it overrides any simultaneous hazard.
REQ-025 Load-use hazard (no stall, no branch) SHALL drive load_front=0, load_back=1, bubble=1, flush_if_id=0 for exactly one cycle per hazard.
REQ-026 Normal advance SHALL drive load_front=1, load_back=1, bubble=0, flush_if_id=0.
REQ-027 MEM_WAIT and IF_WAIT SHALL return to RUN in the cycle the stalling condition clears; outputs in that cycle follow REQ-024..026 combinationally (zero added latency).
REQ-028 A wait counter SHALL count consecutive MEM_WAIT cycles; when it reaches MAX_WAIT, wd_err SHALL set and remain set until reset; the counter clears on leaving MEM_WAIT.
REQ-029 stall_cnt SHALL increment on every cycle with load_back=0 and saturate at 32'hFFFF_FFFF.
REQ-030 flush_cnt SHALL increment on every cycle with flush_if_id=1 and wrap from 16'hFFFF to 0.
REQ-031 A br_taken held high during a stall SHALL produce exactly one flush, in the first non-stalled cycle.

Reset
REQ-032 While reset_n=0: state=RUN, load_front=0, load_back=0, flush_if_id=0, bubble=0, stall_cnt=0, flush_cnt=0, wd_err=0, wait counter=0, regardless of other inputs.
REQ-033 Reset asserted mid-stall SHALL clear the state immediately; the first cycle after release is evaluated from RUN.

Structure
REQ-034 The state enum (pc_state_t) and the all-zero NOP constants for instruction and control word SHALL live in rv32i_types.
REQ-035 Hazard detection (REQ-020) SHALL be a combinational sub-module named hazard_detect; counters and FSM stay in pipeline_ctrl.

Verification
REQ-036 Reset release with imem_resp=1 and no hazards: load_front=load_back=1 every cycle; stall_cnt stays 0.
REQ-037 ex_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1: one cycle with load_front=0, load_back=1, bubble=1; stall_cnt unchanged.
REQ-038 Same hazard with br_taken=1: flush_if_id=1, bubble=1, load_front=1; flush_cnt increments by 1.
REQ-039 dmem_req=1 and dmem_resp=0 for 3 cycles, then 1: three cycles with all loads 0; stall_cnt=3; state returns to RUN.
REQ-040 MAX_WAIT=4 with dmem_resp held 0: wd_err rises after 4 MEM_WAIT cycles and stays 1 after dmem_resp=1.
REQ-041 reset_n pulsed low during MEM_WAIT: outputs and counters are 0 asynchronously; state is RUN after release.
